outbyte_uart_tx_p: RTL and testbench

//   Parametrised Bream-callable UART transmitter: (outbyte outchan byte).

---
 rtl/outbyte_uart_tx_p.sv | 188 ++++++++++++++++++
 tb/tb_outbyte_uart_tx_p.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/outbyte_uart_tx_p.sv
// Buffered UART transmitter behind a Bream-style call interface.
// Provides a transmit FIFO, a per-frame baud divider, configurable parity and stop bits, and an optional mode that blocks the call until the line drains.
module outbyte_uart_tx_p #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 5,
    parameter int DIV_W      = 16,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int BUFFERED   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [DIV_W-1:0]     bps_divider,
    input  logic [DATA_BITS-1:0] byte_to_output,
    output logic                 outchan,
    output logic [CNT_W-1:0]     result,
    output logic                 result_ready
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {TOP_READY, TOP_WAIT_SPACE, TOP_DRAIN} top_state_t;
    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;

    top_state_t top_q, top_d;
    tx_state_t  tx_q, tx_d;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [CNT_W-1:0]     count;
    logic [DATA_BITS-1:0] pend_q;
    logic [DATA_BITS-1:0] push_data;
    logic                 push, pop, latch_pend;

    logic [DIV_W-1:0]     baud_cnt, div_q;
    logic [3:0]           bit_idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_q;

    logic full, can_load, bit_done;

    assign full     = (count == CNT_W'(FIFO_DEPTH));
    assign can_load = (count != '0) && (bps_divider != '0);
    assign bit_done = (baud_cnt == div_q - DIV_W'(1));

    assign result       = count;
    assign result_ready = (top_q == TOP_READY) && !start;

    // Call-side FSM: decides when the caller's byte enters the FIFO.
    always_comb begin
        top_d      = top_q;
        push       = 1'b0;
        push_data  = byte_to_output;
        latch_pend = 1'b0;
        case (top_q)
            TOP_READY: begin
                if (start) begin
                    if (!full) begin
                        push  = 1'b1;
                        top_d = (BUFFERED != 0) ? TOP_READY : TOP_DRAIN;
                    end else begin
                        latch_pend = 1'b1;
                        top_d      = TOP_WAIT_SPACE;
                    end
                end
            end
            TOP_WAIT_SPACE: begin
                push_data = pend_q;
                if (!full) begin
                    push  = 1'b1;
                    top_d = (BUFFERED != 0) ? TOP_READY : TOP_DRAIN;
                end
            end
            TOP_DRAIN: begin
                if (count == '0 && tx_q == TX_IDLE)
                    top_d = TOP_READY;
            end
            default: top_d = TOP_READY;
        endcase
    end

    // Line-side FSM; the last stop-bit cycle may reload directly so frames abut.
    always_comb begin
        tx_d    = tx_q;
        pop     = 1'b0;
        outchan = 1'b1;
        case (tx_q)
            TX_IDLE: begin
                if (can_load) begin
                    pop  = 1'b1;
                    tx_d = TX_START;
                end
            end
            TX_START: begin
                outchan = 1'b0;
                if (bit_done)
                    tx_d = TX_DATA;
            end
            TX_DATA: begin
                outchan = shift_q[0];
                if (bit_done && bit_idx == 4'(DATA_BITS - 1))
                    tx_d = (PARITY != 0) ? TX_PARITY : TX_STOP;
            end
            TX_PARITY: begin
                outchan = par_q;
                if (bit_done)
                    tx_d = TX_STOP;
            end
            TX_STOP: begin
                if (bit_done && stop_idx == 1'(STOP_BITS - 1)) begin
                    if (can_load) begin
                        pop  = 1'b1;
                        tx_d = TX_START;
                    end else begin
                        tx_d = TX_IDLE;
                    end
                end
            end
            default: tx_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            top_q  <= TOP_READY;
            tx_q   <= TX_IDLE;
            pend_q <= '0;
        end else begin
            top_q <= top_d;
            tx_q  <= tx_d;
            if (latch_pend)
                pend_q <= byte_to_output;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            baud_cnt <= '0;
            div_q    <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            shift_q  <= '0;
            par_q    <= 1'b0;
        end else if (pop) begin
            baud_cnt <= '0;
            div_q    <= bps_divider;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            shift_q  <= mem[rd_ptr];
            par_q    <= (^mem[rd_ptr]) ^ (PARITY == 1);
        end else if (tx_q != TX_IDLE) begin
            if (bit_done) begin
                baud_cnt <= '0;
                if (tx_q == TX_DATA) begin
                    shift_q <= shift_q >> 1;
                    bit_idx <= bit_idx + 1'b1;
                end
                if (tx_q == TX_STOP)
                    stop_idx <= stop_idx + 1'b1;
            end else begin
                baud_cnt <= baud_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_outbyte_uart_tx_p.sv
// Randomised bench for outbyte_uart_tx_p: three configurations are checked each cycle against a queue/frame reference model.
// The instances cover 8N1 buffered, even parity with 2 stop bits, and odd parity unbuffered with a shallow FIFO.
module tb_outbyte_uart_tx_p;

    logic       clk = 1'b0;
    logic       rst;
    logic       drv_start [3];
    logic [7:0] drv_byte  [3];
    logic [15:0] drv_div  [3];

    logic [2:0] line;
    logic [2:0] ready;
    logic [4:0] res [3];
    logic [4:0] result0, result1;
    logic [2:0] result2;

    int par   [3] = '{0, 2, 1};
    int stops [3] = '{1, 2, 1};
    int depth [3] = '{16, 16, 4};
    int bufd  [3] = '{1, 1, 0};

    int checks = 0;
    int errors = 0;

    // Reference model: FIFO contents as a circular array, current frame as a bit vector.
    int         mtop [3];
    int         mcnt [3];
    int         mh   [3];
    logic [7:0] mq   [3][32];
    logic [7:0] pend [3];
    logic [15:0] fbits [3];
    int         flen [3];
    int         fdiv [3];
    int         fpos [3];
    bit         factive [3];
    bit         idle_k  [3];

    always #5 clk = ~clk;

    outbyte_uart_tx_p #(.DATA_BITS(8), .FIFO_DEPTH(16), .CNT_W(5), .DIV_W(16),
        .PARITY(0), .STOP_BITS(1), .BUFFERED(1)) dut0 (
        .clk(clk), .rst(rst), .start(drv_start[0]), .bps_divider(drv_div[0]),
        .byte_to_output(drv_byte[0]), .outchan(line[0]), .result(result0),
        .result_ready(ready[0]));

    outbyte_uart_tx_p #(.DATA_BITS(8), .FIFO_DEPTH(16), .CNT_W(5), .DIV_W(16),
        .PARITY(2), .STOP_BITS(2), .BUFFERED(1)) dut1 (
        .clk(clk), .rst(rst), .start(drv_start[1]), .bps_divider(drv_div[1]),
        .byte_to_output(drv_byte[1]), .outchan(line[1]), .result(result1),
        .result_ready(ready[1]));

    outbyte_uart_tx_p #(.DATA_BITS(8), .FIFO_DEPTH(4), .CNT_W(3), .DIV_W(16),
        .PARITY(1), .STOP_BITS(1), .BUFFERED(0)) dut2 (
        .clk(clk), .rst(rst), .start(drv_start[2]), .bps_divider(drv_div[2]),
        .byte_to_output(drv_byte[2]), .outchan(line[2]), .result(result2),
        .result_ready(ready[2]));

    assign res[0] = result0;
    assign res[1] = result1;
    assign res[2] = {2'b00, result2};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            mtop[i] = 0; mcnt[i] = 0; mh[i] = 0;
            factive[i] = 1'b0; fpos[i] = 0; idle_k[i] = 1'b1;
        end
    endtask

    // Compare the current cycle against the model, then advance the frame position.
    task automatic observe();
        logic expl;
        for (int i = 0; i < 3; i++) begin
            idle_k[i] = !factive[i];
            expl = factive[i] ? fbits[i][fpos[i] / fdiv[i]] : 1'b1;
            check_eq($sformatf("line%0d", i), 32'(line[i]), 32'(expl));
            check_eq($sformatf("result%0d", i), 32'(res[i]), 32'(mcnt[i]));
            check_eq($sformatf("ready%0d", i), 32'(ready[i]),
                     32'(mtop[i] == 0 && !drv_start[i]));
            if (factive[i]) begin
                fpos[i]++;
                if (fpos[i] == flen[i] * fdiv[i])
                    factive[i] = 1'b0;
            end
        end
    endtask

    // Effect of the coming clock edge on the model, given the inputs now driven.
    task automatic model_edge();
        int cb, n;
        bit do_pop, do_push;
        logic [7:0] pb, b;
        for (int i = 0; i < 3; i++) begin
            cb = mcnt[i];
            do_pop  = !factive[i] && cb > 0 && drv_div[i] != 0;
            do_push = 1'b0;
            pb = drv_byte[i];
            case (mtop[i])
                0: if (drv_start[i]) begin
                       if (cb < depth[i]) begin
                           do_push = 1'b1;
                           mtop[i] = bufd[i] ? 0 : 2;
                       end else begin
                           pend[i] = drv_byte[i];
                           mtop[i] = 1;
                       end
                   end
                1: if (cb < depth[i]) begin
                       do_push = 1'b1;
                       pb = pend[i];
                       mtop[i] = bufd[i] ? 0 : 2;
                   end
                default: if (cb == 0 && idle_k[i]) mtop[i] = 0;
            endcase
            if (do_push) begin
                mq[i][(mh[i] + cb) % 32] = pb;
                mcnt[i]++;
            end
            if (do_pop) begin
                b = mq[i][mh[i]];
                mh[i] = (mh[i] + 1) % 32;
                mcnt[i]--;
                fbits[i] = '0;
                for (int j = 0; j < 8; j++) fbits[i][1 + j] = b[j];
                n = 9;
                if (par[i] != 0) begin
                    fbits[i][n] = (^b) ^ (par[i] == 1);
                    n++;
                end
                for (int s = 0; s < stops[i]; s++) begin
                    fbits[i][n] = 1'b1;
                    n++;
                end
                flen[i] = n;
                fdiv[i] = int'(drv_div[i]);
                fpos[i] = 0;
                factive[i] = 1'b1;
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        observe();
    endtask

    task automatic idle_inputs();
        for (int i = 0; i < 3; i++) drv_start[i] = 1'b0;
    endtask

    task automatic mid_reset();
        idle_inputs();
        rst = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("rst_line%0d", i), 32'(line[i]), 32'd1);
            check_eq($sformatf("rst_count%0d", i), 32'(res[i]), 32'd0);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        observe();
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drv_start[i] = 1'b0; drv_byte[i] = '0; drv_div[i] = 16'd1;
        end
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        observe();

        // Directed frames: 0x55 @4 (8N1), 0x07 @3 (even, 2 stop), 0xA3 @2 (odd, unbuffered)
        drv_div[0] = 16'd4; drv_div[1] = 16'd3; drv_div[2] = 16'd2;
        drv_byte[0] = 8'h55; drv_byte[1] = 8'h07; drv_byte[2] = 8'hA3;
        for (int i = 0; i < 3; i++) drv_start[i] = 1'b1;
        tick();
        idle_inputs();
        repeat (60) tick();

        // 17 back-to-back calls with the divider parked at 0, then release
        drv_div[0] = 16'd0;
        for (int n = 0; n < 17; n++) begin
            drv_start[0] = 1'b1;
            drv_byte[0]  = 8'(8'h30 + n);
            tick();
        end
        drv_start[0] = 1'b0;
        repeat (6) tick();
        drv_div[0] = 16'd2;
        repeat (400) tick();

        // Queue three bytes everywhere, then reset in the middle of a frame
        for (int i = 0; i < 3; i++) drv_div[i] = 16'd4;
        for (int n = 0; n < 3; n++) begin
            for (int i = 0; i < 3; i++) begin
                drv_start[i] = 1'b1;
                drv_byte[i]  = 8'($urandom);
            end
            tick();
        end
        idle_inputs();
        repeat (10) tick();
        mid_reset();
        repeat (40) tick();

        // Randomised traffic, including starts outside READY and divider 0
        repeat (4000) begin
            for (int i = 0; i < 3; i++) begin
                drv_start[i] = ($urandom_range(0, 3) == 0);
                drv_byte[i]  = 8'($urandom);
                if ($urandom_range(0, 29) == 0)
                    drv_div[i] = 16'($urandom_range(0, 4));
            end
            tick();
        end
        idle_inputs();
        for (int i = 0; i < 3; i++) drv_div[i] = 16'd3;
        repeat (900) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
